// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board dimensions, piece and FSM types, coordinate helpers
package tetris_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_id_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic signed [6:0] sext5(input logic [4:0] v);
    return {{2{v[4]}}, v};
  endfunction

  function automatic logic signed [6:0] sext6(input logic [5:0] v);
    return {v[5], v};
  endfunction

endpackage

// File: rtl/collision_row_eval.sv
// rtl/collision_row_eval.sv - combinational collision test of one piece row against one board row
module collision_row_eval
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic [3:0]         piece_row,
  input  logic signed [6:0]  col0,
  input  logic signed [6:0]  row,
  input  logic [BOARD_W-1:0] board_row,
  output logic               hit
);

  localparam logic signed [6:0] W7 = 7'(BOARD_W);
  localparam logic signed [6:0] H7 = 7'(BOARD_H);

  // piece bit k sits in board column col0 + (3 - k)
  logic signed [6:0] col [4];

  for (genvar k = 0; k < 4; k++) begin : g_col
    assign col[k] = col0 + 7'(3 - k);
  end

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (piece_row[k]) begin
        if (col[k][6] || (col[k] >= W7) || (row >= H7)) begin
          hit = 1'b1;
        end else if (!row[6]) begin
          for (int c = 0; c < BOARD_W; c++) begin
            if ((col[k] == 7'(c)) && board_row[c]) hit = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/collision_check.sv
// rtl/collision_check.sv - row-by-row piece/board collision checker with early exit
module collision_check
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         piece_id,
  input  logic [1:0]         rotation,
  input  logic [4:0]         pos_x,
  input  logic [5:0]         pos_y,
  output logic [2:0]         rom_piece_id,
  output logic [1:0]         rom_rotation,
  output logic [1:0]         rom_row_index,
  input  logic [3:0]         rom_piece_row,
  output logic [4:0]         board_rd_addr,
  input  logic [BOARD_W-1:0] board_rd_data,
  output logic               busy,
  output logic               done,
  output logic               collide
);

  localparam logic signed [6:0] H7 = 7'(BOARD_H);

  state_e            state_q, state_d;
  logic [1:0]        r_q, r_d;
  logic [2:0]        piece_q, piece_d;
  logic [1:0]        rot_q, rot_d;
  logic [4:0]        px_q, px_d;
  logic [5:0]        py_q, py_d;
  logic [4:0]        addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              collide_q, collide_d;
  logic signed [6:0] row_cur, row_nxt;
  logic              row_hit;

  // rows above or below the board read address 0; the evaluator ignores that data
  function automatic logic [4:0] addr_of(input logic signed [6:0] row);
    if (!row[6] && (row < H7)) return row[4:0];
    return 5'd0;
  endfunction

  assign row_cur = sext6(py_q) + {5'd0, r_q};
  assign row_nxt = row_cur + 7'd1;

  collision_row_eval #(
    .BOARD_W(BOARD_W),
    .BOARD_H(BOARD_H)
  ) u_row_eval (
    .piece_row(rom_piece_row),
    .col0     (sext5(px_q)),
    .row      (row_cur),
    .board_row(board_rd_data),
    .hit      (row_hit)
  );

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    piece_d   = piece_q;
    rot_d     = rot_q;
    px_d      = px_q;
    py_d      = py_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    collide_d = collide_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          piece_d   = piece_id;
          rot_d     = rotation;
          px_d      = pos_x;
          py_d      = pos_y;
          r_d       = 2'd0;
          collide_d = 1'b0;
          addr_d    = addr_of(sext6(pos_y));
          busy_d    = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_EVAL;
      ST_EVAL: begin
        if (row_hit || (r_q == 2'd3)) begin
          collide_d = collide_q | row_hit;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          r_d     = r_q + 2'd1;
          addr_d  = addr_of(row_nxt);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      r_q       <= 2'd0;
      piece_q   <= 3'd0;
      rot_q     <= 2'd0;
      px_q      <= 5'd0;
      py_q      <= 6'd0;
      addr_q    <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      piece_q   <= piece_d;
      rot_q     <= rot_d;
      px_q      <= px_d;
      py_q      <= py_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      collide_q <= collide_d;
    end
  end

  assign rom_piece_id  = piece_q;
  assign rom_rotation  = rot_q;
  assign rom_row_index = r_q;
  assign board_rd_addr = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign collide       = collide_q;

endmodule

// File: tb/tb_collision_check.sv
// tb/tb_collision_check.sv - table-driven bench for collision_check with stub ROM and board RAM
module tb_collision_check;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] piece_id;
  logic [1:0] rotation;
  logic [4:0] pos_x;
  logic [5:0] pos_y;
  logic [2:0] rom_piece_id;
  logic [1:0] rom_rotation;
  logic [1:0] rom_row_index;
  logic [3:0] rom_piece_row;
  logic [4:0] board_rd_addr;
  logic [9:0] board_rd_data;
  logic       busy;
  logic       done;
  logic       collide;

  logic [3:0] rom_rows [4];
  logic [9:0] board [32];

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0]       rows;   // row0 in [15:12] .. row3 in [3:0]
    logic signed [4:0] px;
    logic signed [5:0] py;
    int                bro;    // occupied board row, -1 for empty board
    int                bcol;
    int                exp_cyc;
    logic              exp_col;
  } vec_t;

  vec_t vecs [14];

  collision_check dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .piece_id     (piece_id),
    .rotation     (rotation),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .rom_piece_id (rom_piece_id),
    .rom_rotation (rom_rotation),
    .rom_row_index(rom_row_index),
    .rom_piece_row(rom_piece_row),
    .board_rd_addr(board_rd_addr),
    .board_rd_data(board_rd_data),
    .busy         (busy),
    .done         (done),
    .collide      (collide)
  );

  always #5 clk = ~clk;

  assign rom_piece_row = rom_rows[rom_row_index];

  always @(posedge clk) board_rd_data <= board[board_rd_addr];

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic run_check(input vec_t v, input int idx);
    int         got_cyc;
    logic [1:0] maxr;
    logic [2:0] pid;
    logic [1:0] rot;
    pid = 3'(idx % 7);
    rot = 2'(idx);
    for (int b = 0; b < 32; b++) board[b] = '0;
    if (v.bro >= 0) board[v.bro][v.bcol] = 1'b1;
    for (int r = 0; r < 4; r++) rom_rows[r] = v.rows[15-4*r -: 4];
    @(negedge clk);
    start = 1'b1; piece_id = pid; rotation = rot; pos_x = v.px; pos_y = v.py;
    @(posedge clk); #1;
    chk("busy_cycle1", idx, 32'(busy), 32'd1);
    chk("done_cycle1", idx, 32'(done), 32'd0);
    // hostile inputs while busy: must not be latched or restart the check
    start = 1'b1; piece_id = ~pid; rotation = ~rot; pos_x = 5'h10; pos_y = 6'h1f;
    maxr = rom_row_index;
    got_cyc = -1;
    for (int cyc = 2; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      if (rom_row_index > maxr) maxr = rom_row_index;
      if (done) begin
        got_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    chk("done_cycle", idx, 32'(got_cyc), 32'(v.exp_cyc));
    chk("collide", idx, 32'(collide), 32'(v.exp_col));
    chk("busy_at_done", idx, 32'(busy), 32'd0);
    chk("latched_id_rot", idx, 32'({rom_piece_id, rom_rotation}), 32'({pid, rot}));
    chk("rows_fetched", idx, 32'(maxr), 32'((v.exp_cyc - 3) / 2));
    @(posedge clk); #1;
    chk("done_one_cycle", idx, 32'(done), 32'd0);
    chk("collide_held", idx, 32'(collide), 32'(v.exp_col));
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 5'sd3,   6'sd0,   -1, 0, 9, 1'b0};
    vecs[1]  = '{16'h0F00, 5'sd7,   6'sd0,   -1, 0, 5, 1'b1};
    vecs[2]  = '{16'h0004, 5'sd3,   6'sd16,  -1, 0, 9, 1'b0};
    vecs[3]  = '{16'h0004, 5'sd3,   6'sd17,  -1, 0, 9, 1'b1};
    vecs[4]  = '{16'h2000, 5'sd2,   6'sd5,    5, 4, 3, 1'b1};
    vecs[5]  = '{16'h2000, 5'sd3,   6'sd5,    5, 4, 9, 1'b0};
    vecs[6]  = '{16'h6600, 5'sd0,   -6'sd2,   0, 1, 9, 1'b0};
    vecs[7]  = '{16'h8000, -5'sd1,  6'sd0,   -1, 0, 3, 1'b1};
    vecs[8]  = '{16'h0000, 5'h10,   6'h20,    0, 0, 9, 1'b0};
    vecs[9]  = '{16'h0090, 5'sd6,   6'sd18,  -1, 0, 7, 1'b1};
    vecs[10] = '{16'h1000, 5'sd6,   6'sd0,    0, 9, 3, 1'b1};
    vecs[11] = '{16'h8000, 5'sd0,   6'sd31,  -1, 0, 3, 1'b1};
    vecs[12] = '{16'h0100, 5'sd6,   6'sd3,    4, 9, 5, 1'b1};
    vecs[13] = '{16'hF000, 5'sd6,   6'sd19,  -1, 0, 9, 1'b0};

    rst_n = 1'b0; start = 1'b0; piece_id = 3'd0; rotation = 2'd0; pos_x = 5'd0; pos_y = 6'd0;
    for (int r = 0; r < 4; r++) rom_rows[r] = 4'd0;
    for (int b = 0; b < 32; b++) board[b] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 0,
        32'({busy, done, collide, rom_row_index, board_rd_addr, rom_piece_id, rom_rotation}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_check(vecs[i], i);

    // reset in the middle of a full-length check
    for (int r = 0; r < 4; r++) rom_rows[r] = 4'd0;
    @(negedge clk);
    start = 1'b1; piece_id = 3'd5; rotation = 2'd3; pos_x = 5'd3; pos_y = 6'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_abort", 100, 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 100,
        32'({busy, done, collide, rom_row_index, board_rd_addr, rom_piece_id, rom_rotation}), 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("no_done_in_reset", 100 + c, 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    run_check(vecs[4], 101);

    // reset in IDLE clears a held collide result
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("collide_cleared", 102, 32'(collide), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_check(vecs[13], 103);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
